pipelined_decode_stage: RTL and testbench

//  Registered decode stage for the RV32I core: turns the single-cycle decode path into one pipeline stage.

---
 rtl/pipelined_decode_stage.sv | 196 +++++++++++++++++++
 tb/tb_pipelined_decode_stage.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_decode_stage.sv
// RV32I/RV32E decode stage: register file with write bypass, RAW scoreboard,
// and a registered valid/ready output bundle for execute.
module pipelined_decode_stage #(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned NREGS     = 32,
  parameter bit          RF_BYPASS = 1'b1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     instr,
  input  logic            flush,
  input  logic            wb_we,
  input  logic [4:0]      wb_addr,
  input  logic [XLEN-1:0] wb_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] rs1_val,
  output logic [XLEN-1:0] rs2_val,
  output logic [XLEN-1:0] imm,
  output logic [4:0]      rd,
  output logic [3:0]      alu_ctrl,
  output logic            op_b_sel,
  output logic [1:0]      wb_sel,
  output logic [1:0]      pc_sel,
  output logic            mem_we,
  output logic [1:0]      mem_mode,
  output logic            illegal
);

  localparam int unsigned RIW = 5;
  localparam int unsigned IW  = (NREGS > 1) ? $clog2(NREGS) : 1;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  typedef struct packed {
    logic [XLEN-1:0] rs1_val;
    logic [XLEN-1:0] rs2_val;
    logic [XLEN-1:0] imm;
    logic [RIW-1:0]  rd;
    logic [3:0]      alu_ctrl;
    logic            op_b_sel;
    logic [1:0]      wb_sel;
    logic [1:0]      pc_sel;
    logic            mem_we;
    logic [1:0]      mem_mode;
    logic            illegal;
  } bundle_t;

  logic [XLEN-1:0] regs [NREGS];
  logic [NREGS-1:0] sb, sb_next;
  bundle_t dec, bundle;

  logic [6:0]      opcode;
  logic [RIW-1:0]  rd_f, rs1_f, rs2_f;
  logic [2:0]      funct3;
  logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic            uses1, uses2, writes, known, bad;
  logic            byp1, byp2, hz1, hz2, hazard, accept;

  function automatic logic reg_ok(input logic [RIW-1:0] r);
    return 32'(r) < NREGS;
  endfunction

  assign opcode = instr[6:0];
  assign rd_f   = instr[11:7];
  assign funct3 = instr[14:12];
  assign rs1_f  = instr[19:15];
  assign rs2_f  = instr[24:20];

  assign imm_i = XLEN'($signed(instr[31:20]));
  assign imm_s = XLEN'($signed({instr[31:25], instr[11:7]}));
  assign imm_b = XLEN'($signed({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}));
  assign imm_u = XLEN'($signed({instr[31:12], 12'b0}));
  assign imm_j = XLEN'($signed({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}));

  // Same-cycle writeback forwarding into the source operands
  assign byp1 = RF_BYPASS && wb_we && (wb_addr == rs1_f);
  assign byp2 = RF_BYPASS && wb_we && (wb_addr == rs2_f);

  // Instruction decode into the next output bundle
  always_comb begin
    dec    = '0;
    uses1  = 1'b0;
    uses2  = 1'b0;
    writes = 1'b0;
    known  = 1'b1;
    case (opcode)
      OP_LUI, OP_AUIPC: begin
        writes = 1'b1; dec.imm = imm_u; dec.op_b_sel = 1'b1;
      end
      OP_JAL: begin
        writes = 1'b1; dec.imm = imm_j; dec.op_b_sel = 1'b1;
        dec.wb_sel = 2'b10; dec.pc_sel = 2'b10;
      end
      OP_JALR: begin
        uses1 = 1'b1; writes = 1'b1; dec.imm = imm_i; dec.op_b_sel = 1'b1;
        dec.wb_sel = 2'b10; dec.pc_sel = 2'b11;
      end
      OP_BRANCH: begin
        uses1 = 1'b1; uses2 = 1'b1; dec.imm = imm_b;
        dec.alu_ctrl = {1'b0, funct3}; dec.pc_sel = 2'b01;
      end
      OP_LOAD: begin
        uses1 = 1'b1; writes = 1'b1; dec.imm = imm_i; dec.op_b_sel = 1'b1;
        dec.wb_sel = 2'b01; dec.mem_mode = funct3[1:0];
      end
      OP_STORE: begin
        uses1 = 1'b1; uses2 = 1'b1; dec.imm = imm_s; dec.op_b_sel = 1'b1;
        dec.mem_we = 1'b1; dec.mem_mode = funct3[1:0];
      end
      OP_IMM: begin
        uses1 = 1'b1; writes = 1'b1; dec.imm = imm_i; dec.op_b_sel = 1'b1;
        dec.alu_ctrl = {(funct3 == 3'b101) && instr[30], funct3};
      end
      OP_REG: begin
        uses1 = 1'b1; uses2 = 1'b1; writes = 1'b1;
        dec.alu_ctrl = {instr[30], funct3};
      end
      default: known = 1'b0;
    endcase
    bad = (writes && !reg_ok(rd_f)) || (uses1 && !reg_ok(rs1_f)) || (uses2 && !reg_ok(rs2_f));
    dec.illegal = !known || bad;
    if (dec.illegal) begin
      writes     = 1'b0;
      dec.mem_we = 1'b0;
    end
    dec.rd = writes ? rd_f : '0;
    dec.rs1_val = (rs1_f == '0 || !reg_ok(rs1_f)) ? '0 : (byp1 ? wb_data : regs[IW'(rs1_f)]);
    dec.rs2_val = (rs2_f == '0 || !reg_ok(rs2_f)) ? '0 : (byp2 ? wb_data : regs[IW'(rs2_f)]);
  end

  assign hz1    = uses1 && (rs1_f != '0) && reg_ok(rs1_f) && sb[IW'(rs1_f)] && !byp1;
  assign hz2    = uses2 && (rs2_f != '0) && reg_ok(rs2_f) && sb[IW'(rs2_f)] && !byp2;
  assign hazard = hz1 || hz2;

  assign in_ready = !reset && !flush && !hazard && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;

  // Scoreboard: writeback and flush clear, accepted writer sets (set wins)
  always_comb begin
    sb_next = sb;
    if (wb_we && (wb_addr != '0) && reg_ok(wb_addr)) sb_next[IW'(wb_addr)] = 1'b0;
    if (flush && out_valid && (bundle.rd != '0)) sb_next[IW'(bundle.rd)] = 1'b0;
    if (accept && (dec.rd != '0)) sb_next[IW'(dec.rd)] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) sb <= '0;
    else       sb <= sb_next;
  end

  // Register file; x0 is never written
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < int'(NREGS); i++) regs[i] <= '0;
    end else if (wb_we && (wb_addr != '0) && reg_ok(wb_addr)) begin
      regs[IW'(wb_addr)] <= wb_data;
    end
  end

  // Output bundle register: load on accept, drop on flush or consume
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      bundle    <= '0;
    end else if (accept) begin
      out_valid <= 1'b1;
      bundle    <= dec;
    end else if (flush || out_ready) begin
      out_valid <= 1'b0;
    end
  end

  assign rs1_val  = bundle.rs1_val;
  assign rs2_val  = bundle.rs2_val;
  assign imm      = bundle.imm;
  assign rd       = bundle.rd;
  assign alu_ctrl = bundle.alu_ctrl;
  assign op_b_sel = bundle.op_b_sel;
  assign wb_sel   = bundle.wb_sel;
  assign pc_sel   = bundle.pc_sel;
  assign mem_we   = bundle.mem_we;
  assign mem_mode = bundle.mem_mode;
  assign illegal  = bundle.illegal;

endmodule

// File: tb/tb_pipelined_decode_stage.sv
// Directed bench for pipelined_decode_stage: decode table plus hazard, stall,
// flush and reset sequences; a second NREGS=16 instance covers RV32E limits.
module tb_pipelined_decode_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, flush, wb_we, out_ready;
  logic [31:0] instr, wb_data;
  logic [4:0]  wb_addr;
  logic        in_ready, out_valid, op_b_sel, mem_we, illegal;
  logic [31:0] rs1_val, rs2_val, imm;
  logic [4:0]  rd;
  logic [3:0]  alu_ctrl;
  logic [1:0]  wb_sel, pc_sel, mem_mode;

  logic        in_valid_b, flush_b, wb_we_b, out_ready_b;
  logic [31:0] instr_b, wb_data_b;
  logic [4:0]  wb_addr_b;
  logic        in_ready_b, out_valid_b, op_b_sel_b, mem_we_b, illegal_b;
  logic [31:0] rs1_val_b, rs2_val_b, imm_b;
  logic [4:0]  rd_b;
  logic [3:0]  alu_ctrl_b;
  logic [1:0]  wb_sel_b, pc_sel_b, mem_mode_b;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  pipelined_decode_stage #(.XLEN(32), .NREGS(32), .RF_BYPASS(1'b1)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .instr(instr),
    .flush(flush), .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
    .out_valid(out_valid), .out_ready(out_ready), .rs1_val(rs1_val), .rs2_val(rs2_val),
    .imm(imm), .rd(rd), .alu_ctrl(alu_ctrl), .op_b_sel(op_b_sel), .wb_sel(wb_sel),
    .pc_sel(pc_sel), .mem_we(mem_we), .mem_mode(mem_mode), .illegal(illegal));

  pipelined_decode_stage #(.XLEN(32), .NREGS(16), .RF_BYPASS(1'b1)) dut_e (
    .clk(clk), .reset(reset), .in_valid(in_valid_b), .in_ready(in_ready_b), .instr(instr_b),
    .flush(flush_b), .wb_we(wb_we_b), .wb_addr(wb_addr_b), .wb_data(wb_data_b),
    .out_valid(out_valid_b), .out_ready(out_ready_b), .rs1_val(rs1_val_b), .rs2_val(rs2_val_b),
    .imm(imm_b), .rd(rd_b), .alu_ctrl(alu_ctrl_b), .op_b_sel(op_b_sel_b), .wb_sel(wb_sel_b),
    .pc_sel(pc_sel_b), .mem_we(mem_we_b), .mem_mode(mem_mode_b), .illegal(illegal_b));

  typedef struct {
    logic [31:0] instr;
    logic [4:0]  a1; logic [31:0] v1;
    logic [4:0]  a2; logic [31:0] v2;
    bit          c1, c2, ci, full;
    logic [31:0] e1, e2, eimm;
    logic [4:0]  erd;
    logic [3:0]  ealu;
    logic        eobs;
    logic [1:0]  ewb, epc;
    logic        emw;
    logic [1:0]  emode;
    logic        eill;
  } vec_t;

  vec_t tbl[11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wb_write(input logic [4:0] a, input logic [31:0] d);
    wb_we = 1'b1; wb_addr = a; wb_data = d;
    tick();
    wb_we = 1'b0;
  endtask

  // Offer an instruction until accepted (bounded), leave its bundle on the output
  task automatic issue(input logic [31:0] ins, input string name);
    int n;
    in_valid = 1'b1; instr = ins;
    #1;
    n = 0;
    while (!in_ready && n < 20) begin
      tick();
      n++;
    end
    chk({name, " accepted"}, 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic issue_b(input logic [31:0] ins);
    in_valid_b = 1'b1; instr_b = ins;
    #1;
    chk("e in_ready", 32'(in_ready_b), 32'd1);
    tick();
    in_valid_b = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    //            instr         a1 v1            a2 v2        c1 c2 ci full e1            e2        eimm          erd alu     obs wb     pc     mw mode   ill
    tbl[0]  = '{32'h00A08093, 1, 32'd5,        0, 0,        1, 0, 1, 1, 32'd5,        0,        32'd10,       1,  4'b0000, 1, 2'b00, 2'b00, 0, 2'b00, 0};
    tbl[1]  = '{32'h404183B3, 3, 32'd100,      4, 32'd30,   1, 1, 0, 1, 32'd100,      32'd30,   0,            7,  4'b1000, 0, 2'b00, 2'b00, 0, 2'b00, 0};
    tbl[2]  = '{32'h4034D413, 9, 32'h80000000, 0, 0,        1, 0, 1, 1, 32'h80000000, 0,        32'h403,      8,  4'b1101, 1, 2'b00, 2'b00, 0, 2'b00, 0};
    tbl[3]  = '{32'hFE208CE3, 1, 32'h11,       2, 32'h22,   1, 1, 1, 1, 32'h11,       32'h22,   32'hFFFFFFF8, 0,  4'b0000, 0, 2'b00, 2'b01, 0, 2'b00, 0};
    tbl[4]  = '{32'h010000EF, 0, 0,            0, 0,        0, 0, 1, 1, 0,            0,        32'd16,       1,  4'b0000, 1, 2'b10, 2'b10, 0, 2'b00, 0};
    tbl[5]  = '{32'h123452B7, 0, 0,            0, 0,        0, 0, 1, 1, 0,            0,        32'h12345000, 5,  4'b0000, 1, 2'b00, 2'b00, 0, 2'b00, 0};
    tbl[6]  = '{32'hFFF59503, 11, 32'h1000,    0, 0,        1, 0, 1, 1, 32'h1000,     0,        32'hFFFFFFFF, 10, 4'b0000, 1, 2'b01, 2'b00, 0, 2'b01, 0};
    tbl[7]  = '{32'h00008067, 1, 32'h400,      0, 0,        1, 0, 1, 1, 32'h400,      0,        0,            0,  4'b0000, 1, 2'b10, 2'b11, 0, 2'b00, 0};
    tbl[8]  = '{32'h00700193, 0, 32'h55,       0, 0,        1, 0, 1, 1, 0,            0,        32'd7,        3,  4'b0000, 1, 2'b00, 2'b00, 0, 2'b00, 0};
    tbl[9]  = '{32'h00000FFF, 0, 0,            0, 0,        0, 0, 0, 0, 0,            0,        0,            0,  4'b0000, 0, 2'b00, 2'b00, 0, 2'b00, 1};
    tbl[10] = '{32'h00100A13, 0, 0,            0, 0,        1, 0, 1, 1, 0,            0,        32'd1,        20, 4'b0000, 1, 2'b00, 2'b00, 0, 2'b00, 0};

    reset = 1'b1; in_valid = 1'b1; instr = 32'h00A08093; flush = 1'b0;
    wb_we = 1'b0; wb_addr = '0; wb_data = '0; out_ready = 1'b1;
    in_valid_b = 1'b0; instr_b = '0; flush_b = 1'b0; wb_we_b = 1'b0;
    wb_addr_b = '0; wb_data_b = '0; out_ready_b = 1'b1;
    tick(); tick();
    chk("reset in_ready", 32'(in_ready), 32'd0);
    chk("reset out_valid", 32'(out_valid), 32'd0);
    chk("reset rs1_val", rs1_val, 32'd0);
    chk("reset imm", imm, 32'd0);
    chk("reset rd", 32'(rd), 32'd0);
    chk("reset ctrl", {22'd0, alu_ctrl, op_b_sel, wb_sel, pc_sel, mem_we}, 32'd0);
    in_valid = 1'b0;
    reset = 1'b0;
    tick();

    for (int i = 0; i < 11; i++) begin
      wb_write(tbl[i].a1, tbl[i].v1);
      wb_write(tbl[i].a2, tbl[i].v2);
      issue(tbl[i].instr, $sformatf("vec%0d", i));
      chk($sformatf("vec%0d out_valid", i), 32'(out_valid), 32'd1);
      chk($sformatf("vec%0d rd", i), 32'(rd), 32'(tbl[i].erd));
      chk($sformatf("vec%0d illegal", i), 32'(illegal), 32'(tbl[i].eill));
      chk($sformatf("vec%0d mem_we", i), 32'(mem_we), 32'(tbl[i].emw));
      if (tbl[i].c1) chk($sformatf("vec%0d rs1_val", i), rs1_val, tbl[i].e1);
      if (tbl[i].c2) chk($sformatf("vec%0d rs2_val", i), rs2_val, tbl[i].e2);
      if (tbl[i].ci) chk($sformatf("vec%0d imm", i), imm, tbl[i].eimm);
      if (tbl[i].full) begin
        chk($sformatf("vec%0d alu_ctrl", i), 32'(alu_ctrl), 32'(tbl[i].ealu));
        chk($sformatf("vec%0d op_b_sel", i), 32'(op_b_sel), 32'(tbl[i].eobs));
        chk($sformatf("vec%0d wb_sel", i), 32'(wb_sel), 32'(tbl[i].ewb));
        chk($sformatf("vec%0d pc_sel", i), 32'(pc_sel), 32'(tbl[i].epc));
        chk($sformatf("vec%0d mem_mode", i), 32'(mem_mode), 32'(tbl[i].emode));
      end
      if (tbl[i].erd != 5'd0) wb_write(tbl[i].erd, 32'd0);
    end

    // Store accepted in the same cycle its base register is written back
    wb_we = 1'b1; wb_addr = 5'd2; wb_data = 32'hDEADBEEF;
    in_valid = 1'b1; instr = 32'h55312023;
    #1;
    chk("sw in_ready", 32'(in_ready), 32'd1);
    tick();
    wb_we = 1'b0; in_valid = 1'b0;
    chk("sw out_valid", 32'(out_valid), 32'd1);
    chk("sw rs1_val", rs1_val, 32'hDEADBEEF);
    chk("sw rs2_val", rs2_val, 32'd0);
    chk("sw imm", imm, 32'h540);
    chk("sw mem_we", 32'(mem_we), 32'd1);
    chk("sw mem_mode", 32'(mem_mode), 32'd2);
    chk("sw rd", 32'(rd), 32'd0);

    // Load-use hazard: add stalls until x5 is written back
    issue(32'h00002283, "lw");
    chk("lw rd", 32'(rd), 32'd5);
    chk("lw wb_sel", 32'(wb_sel), 32'd1);
    in_valid = 1'b1; instr = 32'h00528333;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk($sformatf("raw stall%0d in_ready", k), 32'(in_ready), 32'd0);
      tick();
    end
    wb_we = 1'b1; wb_addr = 5'd5; wb_data = 32'd7;
    #1;
    chk("raw bypass in_ready", 32'(in_ready), 32'd1);
    tick();
    wb_we = 1'b0; in_valid = 1'b0;
    chk("add rs1_val", rs1_val, 32'd7);
    chk("add rs2_val", rs2_val, 32'd7);
    chk("add rd", 32'(rd), 32'd6);
    wb_write(5'd6, 32'd0);

    // Backpressure: bundle held stable, next instruction waits
    wb_write(5'd1, 32'h20);
    out_ready = 1'b0;
    issue(32'h00A08093, "hold addi");
    in_valid = 1'b1; instr = 32'h00700193;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk($sformatf("hold%0d in_ready", k), 32'(in_ready), 32'd0);
      chk($sformatf("hold%0d out_valid", k), 32'(out_valid), 32'd1);
      chk($sformatf("hold%0d rs1_val", k), rs1_val, 32'h20);
      chk($sformatf("hold%0d imm", k), imm, 32'd10);
      chk($sformatf("hold%0d rd", k), 32'(rd), 32'd1);
      tick();
    end
    out_ready = 1'b1;
    #1;
    chk("hold release in_ready", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    chk("hold next out_valid", 32'(out_valid), 32'd1);
    chk("hold next rd", 32'(rd), 32'd3);
    tick();
    chk("hold drained out_valid", 32'(out_valid), 32'd0);
    wb_write(5'd1, 32'd0);
    wb_write(5'd3, 32'd0);

    // Flush of a pending load releases its scoreboard bit
    out_ready = 1'b0;
    issue(32'h00002283, "flush lw");
    flush = 1'b1; in_valid = 1'b1; instr = 32'h00528333;
    #1;
    chk("flush in_ready", 32'(in_ready), 32'd0);
    tick();
    flush = 1'b0;
    chk("flush out_valid", 32'(out_valid), 32'd0);
    #1;
    chk("post flush in_ready", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    chk("post flush out_valid", 32'(out_valid), 32'd1);
    chk("post flush rd", 32'(rd), 32'd6);
    chk("post flush rs1_val", rs1_val, 32'd7);
    out_ready = 1'b1;
    tick();
    wb_write(5'd6, 32'd0);

    // Reset while a dependent instruction is stalled
    out_ready = 1'b0;
    issue(32'h00002283, "rst lw");
    in_valid = 1'b1; instr = 32'h00528333;
    #1;
    chk("rst stall in_ready", 32'(in_ready), 32'd0);
    reset = 1'b1;
    tick();
    chk("rst out_valid", 32'(out_valid), 32'd0);
    chk("rst rd", 32'(rd), 32'd0);
    chk("rst rs1_val", rs1_val, 32'd0);
    reset = 1'b0;
    #1;
    chk("after rst in_ready", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    chk("after rst out_valid", 32'(out_valid), 32'd1);
    chk("after rst rs1_val", rs1_val, 32'd0);
    chk("after rst rd", 32'(rd), 32'd6);
    out_ready = 1'b1;
    tick();
    wb_write(5'd6, 32'd0);

    // RV32E instance: register index limit and unknown opcode
    issue_b(32'h00100A13);
    chk("e x20 illegal", 32'(illegal_b), 32'd1);
    chk("e x20 rd", 32'(rd_b), 32'd0);
    chk("e x20 out_valid", 32'(out_valid_b), 32'd1);
    issue_b(32'h0000007F);
    chk("e opc illegal", 32'(illegal_b), 32'd1);
    chk("e opc mem_we", 32'(mem_we_b), 32'd0);
    issue_b(32'h00700193);
    chk("e x3 illegal", 32'(illegal_b), 32'd0);
    chk("e x3 rd", 32'(rd_b), 32'd3);
    chk("e x3 imm", imm_b, 32'd7);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
